player_input: RTL and testbench
===============================

Name: player_input

Overview:
- Upstream stage of each player movement block.
- Converts the raw USB keyboard keycodes (four simultaneous slots) into per-player, one-hot, single-cycle step pulses, plus a level "walking" flag for animation selection.
- Handles key mapping, per-player direction priority, first-press immediate step, and hold-to-repeat, all timed in frames.
- One instance serves both players; its outputs feed the player blocks directly.

Parameters:
- REPEAT_DELAY, 12: frames between the first step and the first auto-repeat step while held (legal 1..63).
- REPEAT_PERIOD, 6: frames between subsequent auto-repeat steps (legal 1..63).

Ports:
- Clk  in  1  system clock; all logic is sequential on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-Clk-cycle pulse per video frame; all timing counts these pulses.
- in_game  in  1  high while a round is active; when low, the block is held idle.
- keycodes  in  32  four 8-bit key slots; 8'h00 marks an empty slot; slot order is irrelevant.
- p1_step  out  4  one-hot step pulse {up,down,left,right}, player one.
- p2_step  out  4  one-hot step pulse {up,down,left,right}, player two.
- p1_walking  out  1  level; player one has a mapped direction key held.
- p2_walking  out  1  level; player two has a mapped direction key held.

Behaviour:
- Key map, player one: W=8'h1A up, S=8'h16 down, A=8'h04 left, D=8'h07 right.
- Key map, player two: 8'h52 up, 8'h51 down, 8'h50 left, 8'h4F right.
- Per-player direction: a key counts as held if it appears in any slot. If several keys are held, priority is up > down > left > right. The result is a one-hot or zero 4-bit dir, computed combinationally from keycodes.
- Each player has an independent FSM (IDLE, DELAY, REPEAT) with a 6-bit frame counter cnt and a registered last_dir.
- All FSM evaluation happens only on Clk edges where frame_tick=1. On all other cycles, state, cnt and last_dir hold.
- IDLE:
  - dir!=0: step(dir), last_dir<=dir, cnt<=REPEAT_DELAY-1, go to DELAY.
  - Otherwise stay in IDLE.
- DELAY or REPEAT:
  - dir==0: go to IDLE, with no step.
  - dir!=last_dir (nonzero): immediate step(dir), last_dir<=dir, cnt<=REPEAT_DELAY-1, go to DELAY.
  - dir==last_dir and cnt!=0: cnt<=cnt-1.
  - dir==last_dir and cnt==0: step(dir), cnt<=REPEAT_PERIOD-1, go to (or stay in) REPEAT.
- step(d): the registered pN_step equals d for exactly the one Clk cycle after the frame_tick edge, and is 4'b0000 on every other cycle. Latency from the frame_tick edge to the pulse is 1 Clk.
- pN_walking is registered and updated on frame_tick edges: it is 1 iff the FSM is in DELAY or REPEAT after that update.
- in_game=0 on a frame_tick edge, or at any Clk edge: both FSMs go to IDLE, cnt=0, last_dir=0, steps=0, walking=0. A key already held when in_game rises is treated as a fresh press on the next frame_tick.
- Reset (synchronous, takes precedence over everything) sets:
  - p1_step=p2_step=4'b0000, p1_walking=p2_walking=0.
  - Both FSMs in IDLE, cnt=0, last_dir=0.
- Reset asserted mid-hold discards repeat progress. After release, a still-held key steps on the first frame_tick.
- Players never interact: simultaneous keys for both players produce independent, possibly same-cycle pulses.
- Duplicate keycodes across slots are equivalent to a single occurrence.
- Unmapped keycodes are ignored and do not disturb a held direction.
- With REPEAT_DELAY=1 or REPEAT_PERIOD=1, a step occurs on every frame_tick while held.

Test Plan:
- Reset=1 for 2 cycles, keycodes=32'h0000001A, in_game=1 -> during reset all outputs 0. After release, first frame_tick -> p1_step=4'b1000 for 1 cycle, 1 cycle later; p1_walking=1.
- Hold D (8'h07) for 30 frame_ticks, defaults 12/6 -> p1_step=4'b0001 on ticks 1, 13, 19, 25; zero otherwise; p2_step stays 0.
- Hold 8'h50 and 8'h52 in two slots -> p2_step=4'b1000 only (up beats left). Then drop 8'h52 while holding 8'h50 -> immediate p2_step=4'b0010 on the next tick, and the delay restarts (next left step 12 ticks later).
- Hold 8'h1A and 8'h4F in the same slots word -> p1_step=4'b1000 and p2_step=4'b0001 pulse in the same cycle.
- Hold A for 5 ticks, then in_game=0 for 1 tick, then in_game=1 -> in_game=0 clears walking and steps. On the next tick with A held: immediate p1_step=4'b0010.
- Insert 8'h2C (unmapped) into a slot while W is held in REPEAT -> the cadence is unchanged (steps every 6 ticks). frame_tick low for 100 cycles -> no pulses and cnt frozen.

Source files
------------

// File: rtl/player_input.sv
// Keyboard-to-step front end for both players: maps USB keycodes to a prioritised
// direction per player, then paces one-hot step pulses with first-press and hold-to-repeat timing.
module player_input #(
  parameter int REPEAT_DELAY  = 12,
  parameter int REPEAT_PERIOD = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        in_game,
  input  logic [31:0] keycodes,
  output logic [3:0]  p1_step,
  output logic [3:0]  p2_step,
  output logic        p1_walking,
  output logic        p2_walking
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } state_t;

  localparam logic [5:0] DELAY_LOAD  = 6'(REPEAT_DELAY - 1);
  localparam logic [5:0] PERIOD_LOAD = 6'(REPEAT_PERIOD - 1);

  // map packs the player's keycodes as {up, down, left, right}; result is one-hot or zero.
  function automatic logic [3:0] decode_dir(input logic [31:0] codes, input logic [31:0] map);
    logic [3:0] held;
    logic [3:0] dir;
    held = '0;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 4; k++) begin
        if (codes[8*s +: 8] == map[8*k +: 8]) held[k] = 1'b1;
      end
    end
    if (held[3])      dir = 4'b1000;
    else if (held[2]) dir = 4'b0100;
    else if (held[1]) dir = 4'b0010;
    else if (held[0]) dir = 4'b0001;
    else              dir = 4'b0000;
    return dir;
  endfunction

  for (genvar p = 0; p < 2; p++) begin : g_player
    localparam logic [31:0] KEY_MAP = (p == 0) ? 32'h1A16_0407 : 32'h5251_504F;

    logic [3:0] dir;
    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [3:0] last_dir_q, last_dir_d;
    logic [3:0] step_q, step_d;
    logic       walking_q, walking_d;

    assign dir = decode_dir(keycodes, KEY_MAP);

    always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_dir_d = last_dir_q;
      step_d     = 4'b0000;
      walking_d  = walking_q;

      if (!in_game) begin
        state_d    = IDLE;
        cnt_d      = '0;
        last_dir_d = '0;
        walking_d  = 1'b0;
      end else if (frame_tick) begin
        case (state_q)
          IDLE: begin
            if (dir != 4'b0000) begin
              step_d     = dir;
              last_dir_d = dir;
              cnt_d      = DELAY_LOAD;
              state_d    = DELAY;
            end
          end
          default: begin
            if (dir == 4'b0000) begin
              state_d = IDLE;
            end else if (dir != last_dir_q) begin
              // A new direction restarts the first-press timing from scratch.
              step_d     = dir;
              last_dir_d = dir;
              cnt_d      = DELAY_LOAD;
              state_d    = DELAY;
            end else if (cnt_q != 6'd0) begin
              cnt_d = cnt_q - 6'd1;
            end else begin
              step_d  = dir;
              cnt_d   = PERIOD_LOAD;
              state_d = REPEAT;
            end
          end
        endcase
        walking_d = (state_d != IDLE);
      end
    end

    // NOTE: reset is synchronous and sampled only on the rising edge; all state uses <=.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        last_dir_q <= '0;
        step_q     <= '0;
        walking_q  <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        last_dir_q <= last_dir_d;
        step_q     <= step_d;
        walking_q  <= walking_d;
      end
    end
  end

  assign p1_step    = g_player[0].step_q;
  assign p2_step    = g_player[1].step_q;
  assign p1_walking = g_player[0].walking_q;
  assign p2_walking = g_player[1].walking_q;

endmodule

// File: tb/tb_player_input.sv
// Self-checking bench for player_input: an age-based timing model checked every cycle,
// plus directed scenarios with hand-computed step positions.
module tb_player_input;

  localparam int DLY = 12;
  localparam int PER = 6;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        in_game = 1'b1;
  logic [31:0] keycodes = 32'h0000_001A;
  logic [3:0]  p1_step, p2_step;
  logic        p1_walking, p2_walking;

  int tests = 0;
  int fails = 0;

  player_input #(.REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .in_game    (in_game),
    .keycodes   (keycodes),
    .p1_step    (p1_step),
    .p2_step    (p2_step),
    .p1_walking (p1_walking),
    .p2_walking (p2_walking)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a press starts an age counter; steps fall at age 0, DLY, DLY+PER, DLY+2*PER, ...
  logic [3:0] m_prev [2] = '{4'b0, 4'b0};
  int         m_age  [2] = '{0, 0};
  logic [3:0] m_step [2] = '{4'b0, 4'b0};
  logic       m_walk [2] = '{1'b0, 1'b0};
  bit         model_live = 1'b0;

  function automatic logic [3:0] model_dir(input int p, input logic [31:0] keys);
    logic [7:0] codes [4];
    if (p == 0) codes = '{8'h1A, 8'h16, 8'h04, 8'h07};
    else        codes = '{8'h52, 8'h51, 8'h50, 8'h4F};
    for (int k = 0; k < 4; k++)
      for (int s = 0; s < 4; s++)
        if (keys[8*s +: 8] == codes[k]) return 4'b1000 >> k;
    return 4'b0000;
  endfunction

  always @(posedge Clk) begin
    model_live = 1'b1;
    for (int p = 0; p < 2; p++) begin
      logic [3:0] d;
      m_step[p] = 4'b0000;
      if (Reset || !in_game) begin
        m_prev[p] = 4'b0000;
        m_age[p]  = 0;
        m_walk[p] = 1'b0;
      end else if (frame_tick) begin
        d = model_dir(p, keycodes);
        if (d == 4'b0000) begin
          m_prev[p] = 4'b0000;
        end else if (d != m_prev[p]) begin
          m_step[p] = d;
          m_prev[p] = d;
          m_age[p]  = 0;
        end else begin
          m_age[p]++;
          if (m_age[p] >= DLY && ((m_age[p] - DLY) % PER) == 0) m_step[p] = d;
        end
        m_walk[p] = (m_prev[p] != 4'b0000);
      end
    end
  end

  always @(negedge Clk) begin
    if (model_live) begin
      check("model_p1_step",    {60'b0, p1_step},    {60'b0, m_step[0]});
      check("model_p2_step",    {60'b0, p2_step},    {60'b0, m_step[1]});
      check("model_p1_walking", {63'b0, p1_walking}, {63'b0, m_walk[0]});
      check("model_p2_walking", {63'b0, p2_walking}, {63'b0, m_walk[1]});
    end
  end

  // One frame tick; returns the pulses seen in the cycle after the tick edge.
  task automatic do_tick(output logic [3:0] s1, output logic [3:0] s2);
    @(negedge Clk) frame_tick = 1'b1;
    @(negedge Clk) frame_tick = 1'b0;
    s1 = p1_step;
    s2 = p2_step;
    repeat (2) @(negedge Clk);
  endtask

  // Bit i of h1/h2 is set when tick i (1-based) produced a pulse for that player.
  task automatic run_ticks(input int n, output logic [63:0] h1, output logic [63:0] h2);
    logic [3:0] s1, s2;
    h1 = '0;
    h2 = '0;
    for (int i = 1; i <= n; i++) begin
      do_tick(s1, s2);
      if (s1 != 4'b0000) h1[i] = 1'b1;
      if (s2 != 4'b0000) h2[i] = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  s1, s2;
    logic [63:0] h1, h2;
    int          n;

    repeat (2) @(negedge Clk);
    check("reset_p1_step", {60'b0, p1_step}, 64'h0);
    check("reset_p2_step", {60'b0, p2_step}, 64'h0);
    check("reset_walking", {62'b0, p1_walking, p2_walking}, 64'h0);
    Reset = 1'b0;

    do_tick(s1, s2);
    check("first_press_w", {60'b0, s1}, 64'h8);
    check("first_press_walking", {63'b0, p1_walking}, 64'h1);

    keycodes = 32'h0;
    do_tick(s1, s2);
    check("release_walking", {63'b0, p1_walking}, 64'h0);

    keycodes = 32'h0000_0700;
    run_ticks(30, h1, h2);
    check("hold_d_cadence", h1, 64'h0208_2002);
    check("hold_d_p2_quiet", h2, 64'h0);

    keycodes = 32'h0;
    do_tick(s1, s2);
    keycodes = 32'h0052_0050;
    do_tick(s1, s2);
    check("p2_up_beats_left", {60'b0, s2}, 64'h8);
    check("p2_prio_p1_quiet", {60'b0, s1}, 64'h0);
    run_ticks(3, h1, h2);
    keycodes = 32'h0000_0050;
    do_tick(s1, s2);
    check("p2_left_immediate", {60'b0, s2}, 64'h2);
    run_ticks(12, h1, h2);
    check("p2_left_delay_restart", h2, 64'h1000);

    keycodes = 32'h0;
    do_tick(s1, s2);
    keycodes = 32'h4F00_001A;
    do_tick(s1, s2);
    check("same_cycle_p1", {60'b0, s1}, 64'h8);
    check("same_cycle_p2", {60'b0, s2}, 64'h1);

    keycodes = 32'h0;
    do_tick(s1, s2);
    keycodes = 32'h0004_0000;
    run_ticks(5, h1, h2);
    check("hold_a_first_only", h1, 64'h2);
    in_game = 1'b0;
    do_tick(s1, s2);
    check("out_of_game_step", {60'b0, s1}, 64'h0);
    check("out_of_game_walking", {63'b0, p1_walking}, 64'h0);
    in_game = 1'b1;
    do_tick(s1, s2);
    check("rejoin_fresh_press", {60'b0, s1}, 64'h2);

    keycodes = 32'h0;
    do_tick(s1, s2);
    keycodes = 32'h0000_001A;
    do_tick(s1, s2);
    run_ticks(12, h1, h2);
    check("w_first_repeat", h1, 64'h1000);
    keycodes = 32'h0000_2C1A;
    run_ticks(12, h1, h2);
    check("unmapped_keeps_cadence", h1, 64'h1040);
    n = 0;
    repeat (100) @(negedge Clk) if (p1_step != 4'b0000 || p2_step != 4'b0000) n++;
    check("no_tick_no_pulse", 64'(n), 64'h0);
    run_ticks(6, h1, h2);
    check("cnt_frozen_without_tick", h1, 64'h40);

    keycodes = 32'h0;
    do_tick(s1, s2);
    keycodes = 32'h0707_0707;
    do_tick(s1, s2);
    check("duplicate_slots", {60'b0, s1}, 64'h1);
    run_ticks(12, h1, h2);
    check("duplicate_delay", h1, 64'h1000);

    run_ticks(3, h1, h2);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    check("mid_hold_reset_walking", {63'b0, p1_walking}, 64'h0);
    Reset = 1'b0;
    do_tick(s1, s2);
    check("after_reset_immediate", {60'b0, s1}, 64'h1);

    repeat (3) @(negedge Clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
